// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - register-write scoreboard with per-register pending counters and decode stall
module scoreboard #(
   parameter int NREGS        = 32,
   parameter int MAX_INFLIGHT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       issue_valid,
   input  logic [4:0] issue_rd,
   output logic       issue_ready,
   input  logic       retire_valid,
   input  logic [4:0] retire_rd,
   input  logic       flush,
   input  logic [4:0] rs1_addr_D,
   input  logic [4:0] rs2_addr_D,
   output logic       stall_D,
   output logic [1:0] inflight,
   output logic       underflow_err
);

   // Counters are 2 bits wide, so the in-flight ceiling is also the saturation point.
   localparam logic [1:0] CNT_MAX = 2'(MAX_INFLIGHT);

   logic [1:0] pend      [NREGS];
   logic [1:0] pend_next [NREGS];
   logic [1:0] inflight_next;
   logic       issue_acc;
   logic       retire_eff;
   logic       hit_issue;
   logic       hit_retire;
   logic       stall_rs1;
   logic       stall_rs2;

   // Back-pressure: a same-cycle retire frees a slot, and reset forces the port open.
   always_comb begin
      issue_ready = reset | (inflight < CNT_MAX) | retire_valid;
      issue_acc   = issue_valid & issue_ready;
      retire_eff  = retire_valid & (inflight != 2'd0);
   end

   // Global in-flight count; a matched issue/retire pair cancels out.
   always_comb begin
      inflight_next = inflight;
      if (issue_acc && !retire_eff && inflight != 2'd3)
         inflight_next = inflight + 2'd1;
      else if (!issue_acc && retire_eff)
         inflight_next = inflight - 2'd1;
   end

   // Per-register pending counters; x0 is never tracked and counts saturate both ways.
   always_comb begin
      hit_issue  = 1'b0;
      hit_retire = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         pend_next[r] = pend[r];
         hit_issue    = issue_acc  && (r != 0) && (issue_rd  == 5'(r));
         hit_retire   = retire_eff && (r != 0) && (retire_rd == 5'(r));
         if (hit_issue && !hit_retire) begin
            if (pend[r] != 2'd3)
               pend_next[r] = pend[r] + 2'd1;
         end else if (hit_retire && !hit_issue) begin
            if (pend[r] != 2'd0)
               pend_next[r] = pend[r] - 2'd1;
         end
      end
   end

   // State register: reset beats flush, flush beats any same-cycle issue or retire.
   always_ff @(posedge clk) begin
      if (reset) begin
         inflight <= 2'd0;
         for (int r = 0; r < NREGS; r++)
            pend[r] <= 2'd0;
      end else if (flush) begin
         inflight <= 2'd0;
         for (int r = 0; r < NREGS; r++)
            pend[r] <= 2'd0;
      end else begin
         inflight <= inflight_next;
         for (int r = 0; r < NREGS; r++)
            pend[r] <= pend_next[r];
      end
   end

   // Sticky underflow flag; only reset clears it, and a retire discarded by flush does not raise it.
   always_ff @(posedge clk) begin
      if (reset)
         underflow_err <= 1'b0;
      else if (retire_valid && inflight == 2'd0 && !flush)
         underflow_err <= 1'b1;
   end

   // Decode stall with retire bypass: the last pending write retiring this cycle clears the hazard.
   always_comb begin
      stall_rs1 = (rs1_addr_D != 5'd0) && (pend[rs1_addr_D] != 2'd0) &&
                  !(retire_valid && retire_rd == rs1_addr_D && pend[rs1_addr_D] == 2'd1);
      stall_rs2 = (rs2_addr_D != 5'd0) && (pend[rs2_addr_D] != 2'd0) &&
                  !(retire_valid && retire_rd == rs2_addr_D && pend[rs2_addr_D] == 2'd1);
      stall_D   = !reset && (stall_rs1 || stall_rs2);
   end

endmodule
